// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and the
// memory stage (D): one outstanding access, round-robin ties, timeout, halt.
//
// state    | meaning
// S_IDLE   | no access outstanding; arbitrate or enter halt
// S_BUSY_I | fetch access issued, waiting for m_done or timeout
// S_BUSY_D | data access issued, waiting for m_done or timeout
// S_HALTED | processor halted; nothing issued until reset
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  input  logic        halt,
  output logic        m_en,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_done,
  output logic        err
);

  localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_HALTED} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_last_d, w_last_d_nxt;
  logic          r_halt_pend, w_halt_pend_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_m_en, w_m_en_nxt;
  logic          r_m_wr, w_m_wr_nxt;
  logic [15:0]   r_m_addr, w_m_addr_nxt;
  logic [15:0]   r_m_wdata, w_m_wdata_nxt;
  logic          r_i_done, w_i_done_nxt;
  logic          r_d_done, w_d_done_nxt;
  logic [15:0]   r_i_rdata, w_i_rdata_nxt;
  logic [15:0]   r_d_rdata, w_d_rdata_nxt;
  logic          r_err, w_err_nxt;

  logic          w_i_elig, w_d_elig, w_pick_d, w_timeout;
  logic [15:0]   w_req_addr, w_rsp_data;

  // A requester whose done is high this cycle is still holding its old request.
  assign w_i_elig   = i_req & ~r_i_done;
  assign w_d_elig   = d_req & ~r_d_done;
  assign w_pick_d   = w_d_elig & (~w_i_elig | ~r_last_d);
  assign w_req_addr = w_pick_d ? d_addr : i_addr;
  assign w_rsp_data = (r_state == S_BUSY_D && r_m_wr) ? 16'h0000 : m_rdata;
  assign w_timeout  = (r_cnt == CNT_TC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_d    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_cnt       <= '0;
      r_m_en      <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= 16'h0000;
      r_m_wdata   <= 16'h0000;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_i_rdata   <= 16'h0000;
      r_d_rdata   <= 16'h0000;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_d    <= w_last_d_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_cnt       <= w_cnt_nxt;
      r_m_en      <= w_m_en_nxt;
      r_m_wr      <= w_m_wr_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_m_wdata   <= w_m_wdata_nxt;
      r_i_done    <= w_i_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_d_nxt    = r_last_d;
    w_halt_pend_nxt = r_halt_pend;
    w_cnt_nxt       = r_cnt;
    w_m_en_nxt      = 1'b0;
    w_m_wr_nxt      = r_m_wr;
    w_m_addr_nxt    = r_m_addr;
    w_m_wdata_nxt   = r_m_wdata;
    w_i_done_nxt    = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_err_nxt       = r_err;

    case (r_state)
      S_IDLE: begin
        if (halt || r_halt_pend) begin
          w_state_nxt = S_HALTED;
        end else if (w_i_elig || w_d_elig) begin
          w_last_d_nxt = w_pick_d;
          if (w_req_addr[0]) begin
            // Misaligned: answered locally with zero data, memory untouched.
            w_err_nxt = 1'b1;
            if (w_pick_d) begin
              w_d_done_nxt  = 1'b1;
              w_d_rdata_nxt = 16'h0000;
            end else begin
              w_i_done_nxt  = 1'b1;
              w_i_rdata_nxt = 16'h0000;
            end
          end else begin
            w_state_nxt   = w_pick_d ? S_BUSY_D : S_BUSY_I;
            w_cnt_nxt     = '0;
            w_m_en_nxt    = 1'b1;
            w_m_wr_nxt    = w_pick_d & d_wr;
            w_m_addr_nxt  = w_req_addr;
            w_m_wdata_nxt = w_pick_d ? d_wdata : 16'h0000;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (halt) w_halt_pend_nxt = 1'b1;
        // m_done wins over a simultaneous terminal count.
        if (m_done || w_timeout) begin
          w_state_nxt = S_IDLE;
          if (!m_done) w_err_nxt = 1'b1;
          if (r_state == S_BUSY_D) begin
            w_d_done_nxt  = 1'b1;
            w_d_rdata_nxt = m_done ? w_rsp_data : 16'h0000;
          end else begin
            w_i_done_nxt  = 1'b1;
            w_i_rdata_nxt = m_done ? w_rsp_data : 16'h0000;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign m_en    = r_m_en;
  assign m_wr    = r_m_wr;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_done  = r_i_done;
  assign d_done  = r_d_done;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign err     = r_err;
  assign i_stall = i_req & ~r_i_done;
  assign d_stall = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model that predicts completion cycles arithmetically.
module tb_mem_arbiter;
  localparam int TIMEOUT = 15;

  logic        clk, rst;
  logic        i_req, i_done, i_stall;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_done, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        halt, m_en, m_wr, m_done, err;
  logic [15:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .halt(halt), .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;
  bit rnd_mode = 0;
  int halt_at  = 0;
  int dir_lat  = 0;
  logic [15:0] dir_rdata = 16'h0000;

  // Model: one transaction in flight, granted at edge md_g, memory latency md_lat (0 = never).
  bit md_busy, md_who_d, md_halted, md_hpend, md_last_d, md_err;
  int md_g, md_lat;
  logic        e_m_en, e_m_wr, e_i_done, e_d_done, e_err;
  logic [15:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;

  int cnt_m_en, cnt_i_done, cnt_d_done, i_done_cyc, d_done_cyc;
  bit seen_m_en;
  logic        first_m_wr;
  logic [15:0] first_m_addr, first_m_wdata, last_i_rdata, last_d_rdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a    = 16'($urandom);
    a[0] = ($urandom_range(0, 7) == 0);
    return a;
  endfunction

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + 3;
    return int'($urandom_range(1, 4));
  endfunction

  task automatic clear_obs();
    cnt_m_en = 0; cnt_i_done = 0; cnt_d_done = 0; i_done_cyc = -1; d_done_cyc = -1;
    seen_m_en = 0; first_m_wr = 1'b0; first_m_addr = 16'h0; first_m_wdata = 16'h0;
    last_i_rdata = 16'h0; last_d_rdata = 16'h0;
  endtask

  task automatic tick_check();
    @(negedge clk);
    check_val("m_en", 32'(m_en), 32'(e_m_en));
    if (e_m_en) begin
      check_val("m_addr", 32'(m_addr), 32'(e_m_addr));
      check_val("m_wr", 32'(m_wr), 32'(e_m_wr));
      if (e_m_wr) check_val("m_wdata", 32'(m_wdata), 32'(e_m_wdata));
    end
    check_val("i_done", 32'(i_done), 32'(e_i_done));
    check_val("d_done", 32'(d_done), 32'(e_d_done));
    if (e_i_done) check_val("i_rdata", 32'(i_rdata), 32'(e_i_rdata));
    if (e_d_done) check_val("d_rdata", 32'(d_rdata), 32'(e_d_rdata));
    check_val("err", 32'(err), 32'(e_err));
    check_val("i_stall", 32'(i_stall), 32'(i_req & ~e_i_done));
    check_val("d_stall", 32'(d_stall), 32'(d_req & ~e_d_done));
    if (m_en) begin
      cnt_m_en++;
      if (!seen_m_en) begin
        seen_m_en = 1; first_m_wr = m_wr; first_m_addr = m_addr; first_m_wdata = m_wdata;
      end
    end
    if (i_done) begin cnt_i_done++; i_done_cyc = n; last_i_rdata = i_rdata; end
    if (d_done) begin cnt_d_done++; d_done_cyc = n; last_d_rdata = d_rdata; end
  endtask

  task automatic tick_update();
    logic nx_m_en, nx_i_done, nx_d_done, i_el, d_el, pick_d, fin;
    logic [15:0] a, val;
    nx_m_en = 1'b0; nx_i_done = 1'b0; nx_d_done = 1'b0; fin = 1'b0; val = 16'h0;
    // requesters drop their request after seeing done
    if (i_req && e_i_done) i_req = 1'b0;
    else if (rnd_mode && !i_req && $urandom_range(0, 3) == 0) begin
      i_req = 1'b1; i_addr = rand_addr();
    end
    if (d_req && e_d_done) d_req = 1'b0;
    else if (rnd_mode && !d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1'b1; d_addr = rand_addr(); d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
    end
    if (rnd_mode && n >= halt_at) halt = 1'b1;
    // memory: completes at cycle g+L; stray m_done pulses while nothing is outstanding
    m_done  = 1'b0;
    m_rdata = 16'($urandom);
    if (md_busy) begin
      if (md_lat != 0 && n == md_g + md_lat) begin
        m_done = 1'b1;
        if (!rnd_mode) m_rdata = dir_rdata;
      end
    end else if (rnd_mode && $urandom_range(0, 9) == 0) begin
      m_done = 1'b1;
    end
    // model decision for the edge ending cycle n
    if (md_halted) begin
    end else if (md_busy) begin
      if (halt) md_hpend = 1;
      if (m_done) begin
        fin = 1'b1;
        val = (md_who_d && e_m_wr) ? 16'h0000 : m_rdata;
      end else if (n == md_g + TIMEOUT) begin
        fin = 1'b1; md_err = 1;
      end
      if (fin) begin
        md_busy = 0;
        if (md_who_d) begin nx_d_done = 1'b1; e_d_rdata = val; end
        else begin nx_i_done = 1'b1; e_i_rdata = val; end
      end
    end else begin
      i_el = i_req && !e_i_done;
      d_el = d_req && !e_d_done;
      if (halt || md_hpend) md_halted = 1;
      else if (i_el || d_el) begin
        pick_d = d_el && (!i_el || !md_last_d);
        md_last_d = pick_d;
        a = pick_d ? d_addr : i_addr;
        if (a[0]) begin
          md_err = 1;
          if (pick_d) begin nx_d_done = 1'b1; e_d_rdata = 16'h0; end
          else begin nx_i_done = 1'b1; e_i_rdata = 16'h0; end
        end else begin
          md_busy = 1; md_who_d = pick_d; md_g = n;
          md_lat = rnd_mode ? pick_lat() : dir_lat;
          nx_m_en = 1'b1; e_m_addr = a; e_m_wr = pick_d && d_wr;
          e_m_wdata = pick_d ? d_wdata : 16'h0;
        end
      end
    end
    e_m_en = nx_m_en; e_i_done = nx_i_done; e_d_done = nx_d_done; e_err = md_err;
    n++;
  endtask

  task automatic step();
    tick_check();
    tick_update();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_m_en", 32'(m_en), 32'h0);
    check_val("rst_m_wr", 32'(m_wr), 32'h0);
    check_val("rst_m_addr", 32'(m_addr), 32'h0);
    check_val("rst_m_wdata", 32'(m_wdata), 32'h0);
    check_val("rst_i_done", 32'(i_done), 32'h0);
    check_val("rst_d_done", 32'(d_done), 32'h0);
    check_val("rst_i_rdata", 32'(i_rdata), 32'h0);
    check_val("rst_d_rdata", 32'(d_rdata), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    i_req = 0; i_addr = 16'h0; d_req = 0; d_wr = 0; d_addr = 16'h0; d_wdata = 16'h0;
    halt = 0; m_done = 0; m_rdata = 16'h0;
    md_busy = 0; md_who_d = 0; md_halted = 0; md_hpend = 0; md_last_d = 0; md_err = 0;
    md_g = 0; md_lat = 0;
    e_m_en = 0; e_m_wr = 0; e_i_done = 0; e_d_done = 0; e_err = 0;
    e_m_addr = 16'h0; e_m_wdata = 16'h0; e_i_rdata = 16'h0; e_d_rdata = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  int k;

  initial begin
    rst = 1'b0;
    i_req = 0; i_addr = 16'h0; d_req = 0; d_wr = 0; d_addr = 16'h0; d_wdata = 16'h0;
    halt = 0; m_done = 0; m_rdata = 16'h0;
    clear_obs();

    // single fetch, latency 3
    do_reset(); clear_obs();
    i_req = 1; i_addr = 16'h0010; dir_lat = 3; dir_rdata = 16'hABCD; k = n;
    repeat (8) step();
    check_val("a_m_addr", 32'(first_m_addr), 32'h0010);
    check_val("a_done_cyc", 32'(i_done_cyc), 32'(k + 4));
    check_val("a_rdata", 32'(last_i_rdata), 32'hABCD);
    check_val("a_done_cnt", 32'(cnt_i_done), 32'd1);

    // simultaneous requests from reset: D first, then I
    do_reset(); clear_obs();
    i_req = 1; i_addr = 16'h0040; d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    dir_lat = 2; dir_rdata = 16'h7777;
    repeat (14) step();
    check_val("b_first_wr", 32'(first_m_wr), 32'd1);
    check_val("b_first_wdata", 32'(first_m_wdata), 32'h1234);
    check_val("b_d_cnt", 32'(cnt_d_done), 32'd1);
    check_val("b_i_cnt", 32'(cnt_i_done), 32'd1);
    check_val("b_i_after_d", 32'(i_done_cyc), 32'(d_done_cyc + 3));
    check_val("b_m_en_cnt", 32'(cnt_m_en), 32'd2);

    // misaligned data read
    do_reset(); clear_obs();
    d_req = 1; d_wr = 0; d_addr = 16'h0003; k = n;
    repeat (4) step();
    check_val("c_m_en_cnt", 32'(cnt_m_en), 32'd0);
    check_val("c_err", 32'(err), 32'd1);
    check_val("c_done_cyc", 32'(d_done_cyc), 32'(k + 1));
    check_val("c_rdata", 32'(last_d_rdata), 32'h0);

    // memory never answers: timeout
    do_reset(); clear_obs();
    i_req = 1; i_addr = 16'h0010; dir_lat = 0; k = n;
    repeat (20) step();
    check_val("d1_done_cyc", 32'(i_done_cyc), 32'(k + TIMEOUT + 1));
    check_val("d1_err", 32'(err), 32'd1);

    // answer on exactly the terminal-count cycle
    do_reset(); clear_obs();
    i_req = 1; i_addr = 16'h0010; dir_lat = TIMEOUT; dir_rdata = 16'h5A5A; k = n;
    repeat (20) step();
    check_val("d2_done_cyc", 32'(i_done_cyc), 32'(k + TIMEOUT + 1));
    check_val("d2_err", 32'(err), 32'd0);
    check_val("d2_rdata", 32'(last_i_rdata), 32'h5A5A);

    // halt in the middle of a data read
    do_reset(); clear_obs();
    d_req = 1; d_wr = 0; d_addr = 16'h0030; dir_lat = 4; dir_rdata = 16'h0F0F;
    step(); step();
    tick_check();
    halt = 1; i_req = 1; i_addr = 16'h0012;
    tick_update();
    repeat (15) step();
    check_val("e_d_cnt", 32'(cnt_d_done), 32'd1);
    check_val("e_d_rdata", 32'(last_d_rdata), 32'h0F0F);
    check_val("e_m_en_cnt", 32'(cnt_m_en), 32'd1);
    check_val("e_i_cnt", 32'(cnt_i_done), 32'd0);
    check_val("e_i_stall", 32'(i_stall), 32'd1);

    // reset while a fetch is outstanding
    do_reset(); clear_obs();
    i_req = 1; i_addr = 16'h0050; dir_lat = 6;
    repeat (3) step();
    do_reset(); clear_obs();
    repeat (10) step();
    check_val("f_i_cnt", 32'(cnt_i_done), 32'd0);
    check_val("f_m_en_cnt", 32'(cnt_m_en), 32'd0);
    tick_check();
    i_req = 1; i_addr = 16'h0060; dir_lat = 2; dir_rdata = 16'h4321;
    tick_update();
    repeat (6) step();
    check_val("f_fresh_cnt", 32'(cnt_i_done), 32'd1);
    check_val("f_fresh_rdata", 32'(last_i_rdata), 32'h4321);

    // randomized traffic, halting near the end
    do_reset(); clear_obs();
    rnd_mode = 1; halt_at = n + 2500;
    repeat (3000) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
